demod_segmenter_ctrl: RTL and testbench

Parametrised demodulation segmenter with start/valid/busy control. It captures one DATA_W-bit demodulated input word on start and slices it into NUM_SEG symbol fields of SEG_BITS each. Each field is zero-extended to OUT_W and presented on registered outputs after a programmable LATENCY. Sits in the Modulation_Pipe receive path between the bit demodulator and symbol consumers; it generalises the fixed 10-segment/3-cycle control wrapper and adds back-pressure, back-to-back restart and overrun flagging.

---
 rtl/demod_pkg.sv | 34 +++
 rtl/demod_gray_decode.sv | 15 +
 rtl/demod_segmenter_ctrl.sv | 115 +++++++++++
 tb/tb_demod_segmenter_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// demod_pkg: shared types and constants for the demod segmenter.
// Holds the FSM state enum, default widths and parameter checks.
package demod_pkg;

  localparam int DEMOD_DATA_W   = 32;
  localparam int DEMOD_SEG_BITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } demod_state_e;

  function automatic bit demod_fit_ok(
    input int data_w,
    input int seg_bits,
    input int num_seg
  );
    return (num_seg * seg_bits) <= data_w;
  endfunction

  function automatic bit demod_params_ok(
    input int data_w,
    input int seg_bits,
    input int num_seg,
    input int out_w,
    input int latency
  );
    return demod_fit_ok(data_w, seg_bits, num_seg)
        && (seg_bits <= out_w)
        && (latency >= 1);
  endfunction

endpackage

// File: rtl/demod_gray_decode.sv
// demod_gray_decode: combinational Gray-to-binary for one symbol.
// Ports: g (Gray in, W bits), b (binary out, W bits).
module demod_gray_decode #(
  parameter int W = 3
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  // b[i] is the XOR of every Gray bit at or above i.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end

endmodule

// File: rtl/demod_segmenter_ctrl.sv
// demod_segmenter_ctrl: captures a word on start, slices it into
// NUM_SEG zero-extended symbol fields after LATENCY edges.
// Ports: clk, reset (sync, active-high), start, in_data[DATA_W],
//   out_ready -> segments[NUM_SEG*OUT_W], valid, busy, overrun.
// Option: DEMOD_GRAY_DECODE_EN Gray-decodes each field.
module demod_segmenter_ctrl
  import demod_pkg::*;
#(
  parameter int DATA_W   = DEMOD_DATA_W,
  parameter int SEG_BITS = DEMOD_SEG_BITS,
  parameter int NUM_SEG  = 10,
  parameter int OUT_W    = 32,
  parameter int LATENCY  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     out_ready,
  output logic [NUM_SEG*OUT_W-1:0] segments,
  output logic                     valid,
  output logic                     busy,
  output logic                     overrun
);

  if (!demod_params_ok(DATA_W, SEG_BITS, NUM_SEG,
                       OUT_W, LATENCY)) begin : g_bad_params
    $error("demod_segmenter_ctrl: illegal parameters");
  end

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  demod_state_e       state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  data_q;

  logic [SEG_BITS-1:0]      raw  [NUM_SEG];
  logic [SEG_BITS-1:0]      fld  [NUM_SEG];
  logic [NUM_SEG*OUT_W-1:0] seg_next;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    assign raw[k] = data_q[k*SEG_BITS +: SEG_BITS];
`ifdef DEMOD_GRAY_DECODE_EN
    demod_gray_decode #(
      .W (SEG_BITS)
    ) u_gray (
      .g (raw[k]),
      .b (fld[k])
    );
`else
    assign fld[k] = raw[k];
`endif
  end

  always_comb begin
    seg_next = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      seg_next[k*OUT_W +: SEG_BITS] = fld[k];
    end
  end

  // Bits of data_q above the last field are deliberately dropped.
  logic unused_data;
  assign unused_data = ^data_q;

  assign busy  = (state == RUN);
  assign valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      segments <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            data_q <= in_data;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          overrun <= start;
          if (cnt == CNT_LAST) begin
            segments <= seg_next;
            state    <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (start) begin
              // back-to-back: skip IDLE entirely
              data_q <= in_data;
              cnt    <= '0;
              state  <= RUN;
            end else begin
              state <= IDLE;
            end
          end else begin
            overrun <= start;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_segmenter_ctrl.sv
// tb_demod_segmenter_ctrl: directed bench for the segmenter.
// Default parameters; expectations follow DEMOD_GRAY_DECODE_EN.
module tb_demod_segmenter_ctrl;
  import demod_pkg::*;

  localparam int NSEG = 10;
  localparam int OW   = 32;
  localparam int BW   = NSEG * OW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   in_data;
  logic          out_ready;
  logic [BW-1:0] segments;
  logic          valid;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_errors = 0;

  demod_segmenter_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .out_ready (out_ready),
    .segments  (segments),
    .valid     (valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string         tag,
    input logic [BW-1:0] got,
    input logic [BW-1:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] mk_segs(
    input int s0, input int s1,
    input int s2, input int s3
  );
    logic [BW-1:0] v;
    v = '0;
    v[0*OW +: OW] = OW'(s0);
    v[1*OW +: OW] = OW'(s1);
    v[2*OW +: OW] = OW'(s2);
    v[3*OW +: OW] = OW'(s3);
    return v;
  endfunction

  logic [BW-1:0] exp_fac;
  logic [BW-1:0] exp_7;

  initial begin
`ifdef DEMOD_GRAY_DECODE_EN
    exp_fac = mk_segs(7, 6, 4, 5);
    exp_7   = mk_segs(5, 0, 0, 0);
`else
    exp_fac = mk_segs(4, 5, 6, 7);
    exp_7   = mk_segs(7, 0, 0, 0);
`endif
    reset     = 1'b1;
    start     = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", BW'(valid), BW'(0));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_ovr", BW'(overrun), BW'(0));
    chk("rst_segs", segments, '0);

    // capture 0xFAC, then a dropped start while running
    start   = 1'b1;
    in_data = 32'h0000_0FAC;
    tick();
    chk("e0_busy", BW'(busy), BW'(1));
    chk("e0_valid", BW'(valid), BW'(0));
    in_data = 32'h0000_0123;
    tick();
    start = 1'b0;
    chk("e1_ovr", BW'(overrun), BW'(1));
    chk("e1_busy", BW'(busy), BW'(1));
    tick();
    chk("e2_ovr", BW'(overrun), BW'(0));
    chk("e2_valid", BW'(valid), BW'(0));
    tick();
    chk("e3_valid", BW'(valid), BW'(1));
    chk("e3_busy", BW'(busy), BW'(0));
    chk("e3_segs", segments, exp_fac);

    // back-pressure: hold 5 cycles, one start dropped
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      tick();
      chk("hold_valid", BW'(valid), BW'(1));
      chk("hold_segs", segments, exp_fac);
      chk("hold_ovr", BW'(overrun), BW'(i == 1));
    end

    // back-to-back restart
    out_ready = 1'b1;
    start     = 1'b1;
    in_data   = 32'h0000_0007;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("b2b_busy", BW'(busy), BW'(1));
    chk("b2b_valid", BW'(valid), BW'(0));
    tick();
    tick();
    chk("b2b_e2_valid", BW'(valid), BW'(0));
    tick();
    chk("b2b_valid3", BW'(valid), BW'(1));
    chk("b2b_segs", segments, exp_7);

    // release to idle; segments keep their value
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_valid", BW'(valid), BW'(0));
    chk("rel_busy", BW'(busy), BW'(0));
    chk("rel_segs", segments, exp_7);

    // reset while running
    start   = 1'b1;
    in_data = 32'h0000_0FAC;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", BW'(busy), BW'(0));
    chk("mrst_valid", BW'(valid), BW'(0));
    chk("mrst_segs", segments, '0);
    start   = 1'b1;
    in_data = 32'h0000_0007;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mrst_e2_valid", BW'(valid), BW'(0));
    tick();
    chk("mrst_e3_valid", BW'(valid), BW'(1));
    chk("mrst_segs2", segments, exp_7);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
